ahblite_bus_arbiter: RTL

Two-master AHB-Lite arbiter placed in front of the address decoder and slave multiplexer. It lets the Cortex-M0 (master 0) and a second bus master such as a DMA engine (master 1) share the single AHB-Lite system bus. Ownership of the address phase changes only at safe points, where the current owner issues IDLE while HREADY is high. A master that is not granted is stalled by holding its HREADY low. No transfer is ever buffered or replayed.

---
 rtl/ahblite_bus_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ahblite_bus_arbiter.sv
// Two-master AHB-Lite arbiter: address phase muxed from the registered owner, ownership moves one
// cycle after an IDLE/HREADY=1 switch point; non-owners are stalled via HREADY=0, nothing is buffered.
module ahblite_bus_arbiter #(
  parameter int ARB_MODE      = 0,
  parameter int DEFAULT_OWNER = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,

  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M0_HBURST,
  input  logic [3:0]  M0_HPROT,
  input  logic [31:0] M0_HWDATA,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HREADY,
  output logic        M0_HRESP,

  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [2:0]  M1_HBURST,
  input  logic [3:0]  M1_HPROT,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HREADY,
  output logic        M1_HRESP,

  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,

  output logic [1:0]  GRANT,
  output logic        DP_OWNER,
  output logic        DP_VALID
);

  localparam logic       DEF_OWNER = (DEFAULT_OWNER != 0);
  localparam logic [1:0] TR_IDLE   = 2'b00;

  logic aowner_q, aowner_d;
  logic downer_q, downer_d;
  logic dvalid_q, dvalid_d;
  logic last_q,   last_d;

  logic req0, req1;
  logic arb_vld, arb_sel;
  logic switch_pt;

  assign req0 = M0_HTRANS[1];
  assign req1 = M1_HTRANS[1];

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      aowner_q <= DEF_OWNER;
      downer_q <= DEF_OWNER;
      dvalid_q <= 1'b0;
      last_q   <= DEF_OWNER;
    end else begin
      aowner_q <= aowner_d;
      downer_q <= downer_d;
      dvalid_q <= dvalid_d;
      last_q   <= last_d;
    end
  end

  // Candidate winner; the both-requesting branch only matters if the owner is IDLE while requesting,
  // which the request encoding rules out, but keeps the policy explicit.
  always_comb begin
    arb_vld = 1'b0;
    arb_sel = aowner_q;
    if (req0 && req1) begin
      arb_vld = 1'b1;
      arb_sel = (ARB_MODE == 0) ? 1'b0 : ~last_q;
    end else if (req0) begin
      arb_vld = 1'b1;
      arb_sel = 1'b0;
    end else if (req1) begin
      arb_vld = 1'b1;
      arb_sel = 1'b1;
    end
  end

  assign switch_pt = HREADY && (HTRANS == TR_IDLE) && arb_vld && (arb_sel != aowner_q);

  // Next-state
  always_comb begin
    aowner_d = aowner_q;
    downer_d = downer_q;
    dvalid_d = dvalid_q;
    last_d   = last_q;
    if (HREADY) begin
      downer_d = aowner_q;
      dvalid_d = HTRANS[1];
      if (switch_pt) begin
        aowner_d = arb_sel;
        last_d   = aowner_q;
      end
    end
  end

  // Outputs: address/control from the address owner, write data and responses follow the data owner
  always_comb begin
    GRANT     = {aowner_q, ~aowner_q};
    HADDR     = aowner_q ? M1_HADDR  : M0_HADDR;
    HTRANS    = aowner_q ? M1_HTRANS : M0_HTRANS;
    HWRITE    = aowner_q ? M1_HWRITE : M0_HWRITE;
    HSIZE     = aowner_q ? M1_HSIZE  : M0_HSIZE;
    HBURST    = aowner_q ? M1_HBURST : M0_HBURST;
    HPROT     = aowner_q ? M1_HPROT  : M0_HPROT;
    HWDATA    = downer_q ? M1_HWDATA : M0_HWDATA;
    M0_HRDATA = HRDATA;
    M1_HRDATA = HRDATA;
    M0_HREADY = HREADY & (~aowner_q | (~downer_q & dvalid_q));
    M1_HREADY = HREADY & ( aowner_q | ( downer_q & dvalid_q));
    M0_HRESP  = HRESP & dvalid_q & ~downer_q;
    M1_HRESP  = HRESP & dvalid_q &  downer_q;
    DP_OWNER  = downer_q;
    DP_VALID  = dvalid_q;
  end

  a_wait_holds_grant: assert property (@(posedge HCLK) disable iff (HRESET)
    !HREADY |=> $stable(GRANT));

  a_burst_not_split: assert property (@(posedge HCLK) disable iff (HRESET)
    (HREADY && HTRANS[0]) |=> $stable(GRANT));

endmodule
